// File: rtl/dma_pkg.sv
// dma_pkg: shared widths, default access length and sequencer state encoding
package dma_pkg;
  localparam int DMA_AW = 21;
  localparam int DMA_DW = 8;
  localparam int ACC_CYCLES_DEF = 2;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_ACCESS, SEQ_DONE} seq_state_e;
endpackage

// File: rtl/dma_sequencer_if.sv
// dma_sequencer_if: requestor handshake plus SRAM bus seen by the sequencer
interface dma_sequencer_if #(parameter int NREQ = 2);
  import dma_pkg::*;
  logic [NREQ-1:0] dma_req;
  logic [NREQ-1:0] dma_rnw;
  logic [DMA_AW*NREQ-1:0] dma_addr;
  logic [DMA_DW*NREQ-1:0] dma_wd;
  logic [NREQ-1:0] dma_ack;
  logic [NREQ-1:0] dma_end;
  logic [DMA_DW-1:0] dma_rd;
  logic mem_slot;
  logic mem_sel;
  logic [DMA_AW-1:0] mem_addr;
  logic mem_rnw;
  logic [DMA_DW-1:0] mem_wd;
  logic [DMA_DW-1:0] mem_rd;
  modport slave (
    input dma_req, dma_rnw, dma_addr, dma_wd, mem_slot, mem_rd,
    output dma_ack, dma_end, dma_rd, mem_sel, mem_addr, mem_rnw, mem_wd
  );
  modport master (
    output dma_req, dma_rnw, dma_addr, dma_wd, mem_slot, mem_rd,
    input dma_ack, dma_end, dma_rd, mem_sel, mem_addr, mem_rnw, mem_wd
  );
endinterface

// File: rtl/dma_sequencer_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning upward from rr_ptr+1
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  int c;
  always_comb begin
    gnt = '0;
    idx = '0;
    c = 0;
    // descending scan so the closest channel after rr_ptr is assigned last and wins
    for (int i = NREQ; i >= 1; i--) begin
      c = (int'(rr_ptr) + i) % NREQ;
      if (en && req[c]) begin
        gnt = NREQ'(1) << c;
        idx = IW'(c);
      end
    end
  end
endmodule

// File: rtl/dma_sequencer.sv
// dma_sequencer: round-robin DMA arbitration, one SRAM byte access per free memory slot
module dma_sequencer
  import dma_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ACC_CYCLES = ACC_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  dma_sequencer_if.slave bus,
  output logic busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  seq_state_e state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, gnt_q, gnt_d, idx;
  logic [3:0] cnt_q, cnt_d;
  logic [DMA_AW-1:0] addr_q, addr_d;
  logic rnw_q, rnw_d;
  logic [DMA_DW-1:0] wd_q, wd_d, rd_q, rd_d;
  logic [NREQ-1:0] gnt;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(bus.dma_req),
    .rr_ptr(rr_q),
    .en(state_q == SEQ_IDLE && bus.mem_slot),
    .gnt(gnt),
    .idx(idx)
  );
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    rnw_d = rnw_q;
    wd_d = wd_q;
    rd_d = rd_q;
    case (state_q)
      SEQ_IDLE: if (|gnt) begin
        state_d = SEQ_ACCESS;
        rr_d = idx;
        gnt_d = idx;
        cnt_d = 4'(ACC_CYCLES - 1);
        addr_d = bus.dma_addr[int'(idx)*DMA_AW +: DMA_AW];
        rnw_d = bus.dma_rnw[idx];
        wd_d = bus.dma_wd[int'(idx)*DMA_DW +: DMA_DW];
      end
      SEQ_ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd0) ? SEQ_DONE : SEQ_ACCESS;
        rd_d = (cnt_q == 4'd0 && rnw_q) ? bus.mem_rd : rd_q;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
      rr_q <= '0;
      gnt_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      rnw_q <= 1'b1;
      wd_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      rnw_q <= rnw_d;
      wd_q <= wd_d;
      rd_q <= rd_d;
    end
  end
  assign bus.dma_ack = gnt;
  assign bus.dma_end = (state_q == SEQ_DONE) ? NREQ'(1) << gnt_q : '0;
  assign bus.dma_rd = rd_q;
  assign bus.mem_sel = state_q == SEQ_ACCESS;
  assign bus.mem_addr = addr_q;
  assign bus.mem_rnw = rnw_q;
  assign bus.mem_wd = wd_q;
  assign busy = state_q != SEQ_IDLE;
endmodule

// File: tb/tb_dma_sequencer.sv
// tb_dma_sequencer: directed checks on a 2-cycle and a 1-cycle access build
module tb_dma_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy0, busy1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  dma_sequencer_if #(.NREQ(2)) b();
  dma_sequencer_if #(.NREQ(2)) c();
  dma_sequencer #(.NREQ(2), .ACC_CYCLES(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(b.slave), .busy(busy0));
  dma_sequencer #(.NREQ(2), .ACC_CYCLES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(c.slave), .busy(busy1));
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    b.dma_req = '0; b.dma_rnw = '0; b.dma_addr = '0; b.dma_wd = '0; b.mem_slot = 0; b.mem_rd = '0;
    c.dma_req = '0; c.dma_rnw = '0; c.dma_addr = '0; c.dma_wd = '0; c.mem_slot = 0; c.mem_rd = '0;
    tick(); tick();
    chk("rst_ack", 32'(b.dma_ack), 0);
    chk("rst_end", 32'(b.dma_end), 0);
    chk("rst_rd", 32'(b.dma_rd), 0);
    chk("rst_sel", 32'(b.mem_sel), 0);
    chk("rst_addr", 32'(b.mem_addr), 0);
    chk("rst_rnw", 32'(b.mem_rnw), 1);
    chk("rst_wd", 32'(b.mem_wd), 0);
    chk("rst_busy", 32'(busy0), 0);
    rst_n = 1'b1;
    tick();
    // single read on ch0
    b.dma_req = 2'b01; b.dma_rnw = 2'b01; b.dma_addr[20:0] = 21'h012345; b.mem_rd = 8'hA5; b.mem_slot = 1;
    #1 chk("rd_ack", 32'(b.dma_ack), 32'h1);
    tick();
    b.dma_req = '0; b.mem_slot = 0;
    for (int i = 0; i < 2; i++) begin
      chk("rd_sel", 32'(b.mem_sel), 1);
      chk("rd_addr", 32'(b.mem_addr), 32'h12345);
      chk("rd_rnw", 32'(b.mem_rnw), 1);
      chk("rd_end_early", 32'(b.dma_end), 0);
      tick();
    end
    chk("rd_end", 32'(b.dma_end), 32'h1);
    chk("rd_sel_done", 32'(b.mem_sel), 0);
    chk("rd_data", 32'(b.dma_rd), 32'hA5);
    tick();
    chk("rd_end_off", 32'(b.dma_end), 0);
    chk("rd_hold", 32'(b.dma_rd), 32'hA5);
    chk("rd_busy", 32'(busy0), 0);
    // write on ch1
    b.dma_req = 2'b10; b.dma_rnw = 2'b00; b.dma_addr[41:21] = 21'h1FFFFF; b.dma_wd[15:8] = 8'h3C; b.mem_rd = 8'h99; b.mem_slot = 1;
    #1 chk("wr_ack", 32'(b.dma_ack), 32'h2);
    tick();
    b.dma_req = '0; b.mem_slot = 0;
    for (int i = 0; i < 2; i++) begin
      chk("wr_sel", 32'(b.mem_sel), 1);
      chk("wr_rnw", 32'(b.mem_rnw), 0);
      chk("wr_wd", 32'(b.mem_wd), 32'h3C);
      chk("wr_addr", 32'(b.mem_addr), 32'h1FFFFF);
      tick();
    end
    chk("wr_end", 32'(b.dma_end), 32'h2);
    chk("wr_rd_keep", 32'(b.dma_rd), 32'hA5);
    tick();
    chk("wr_rd_keep2", 32'(b.dma_rd), 32'hA5);
    // round-robin from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    b.dma_req = 2'b11; b.dma_rnw = 2'b11;
    for (int k = 0; k < 6; k++) begin
      b.mem_slot = 1;
      #1 chk("rr_ack", 32'(b.dma_ack), (k % 2 == 0) ? 32'h2 : 32'h1);
      tick();
      b.mem_slot = 0;
      chk("rr_busy_ack", 32'(b.dma_ack), 0);
      tick();
      b.mem_slot = 1;
      #1 chk("rr_slot_access", 32'(b.dma_ack), 0);
      tick();
      #1 chk("rr_slot_done", 32'(b.dma_ack), 0);
      chk("rr_end", 32'(b.dma_end), (k % 2 == 0) ? 32'h2 : 32'h1);
      tick();
      b.mem_slot = 0;
      #1 chk("rr_idle_noslot", 32'(b.dma_ack), 0);
      tick();
    end
    b.dma_req = '0;
    // pulsed request without slot is dropped
    b.dma_req = 2'b01; b.dma_rnw = 2'b01;
    tick();
    b.dma_req = '0;
    tick();
    b.mem_slot = 1;
    #1 chk("pulse_noack", 32'(b.dma_ack), 0);
    tick();
    b.mem_slot = 0;
    chk("pulse_nosel", 32'(b.mem_sel), 0);
    chk("pulse_idle", 32'(busy0), 0);
    // pulse coincident with slot, address bumps right after the ack edge
    b.dma_req = 2'b01; b.dma_addr[20:0] = 21'h000100; b.mem_rd = 8'h77; b.mem_slot = 1;
    #1 chk("pulse_ack", 32'(b.dma_ack), 32'h1);
    tick();
    b.dma_req = '0; b.mem_slot = 0; b.dma_addr[20:0] = 21'h000101;
    chk("pulse_addr", 32'(b.mem_addr), 32'h100);
    tick(); tick();
    chk("pulse_end", 32'(b.dma_end), 32'h1);
    chk("pulse_rd", 32'(b.dma_rd), 32'h77);
    tick();
    // reset in the first access cycle aborts the transfer
    b.dma_req = 2'b01; b.mem_rd = 8'hC3; b.mem_slot = 1;
    tick();
    b.dma_req = '0; b.mem_slot = 0;
    chk("abort_sel_pre", 32'(b.mem_sel), 1);
    rst_n = 1'b0;
    #1 chk("abort_sel", 32'(b.mem_sel), 0);
    chk("abort_rd", 32'(b.dma_rd), 0);
    chk("abort_busy", 32'(busy0), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_noend", 32'(b.dma_end), 0);
    end
    rst_n = 1'b1;
    tick();
    chk("abort_after_end", 32'(b.dma_end), 0);
    b.dma_req = 2'b01; b.mem_slot = 1;
    #1 chk("abort_next_ack", 32'(b.dma_ack), 32'h1);
    tick();
    b.dma_req = '0; b.mem_slot = 0;
    tick(); tick();
    chk("abort_next_end", 32'(b.dma_end), 32'h1);
    chk("abort_next_rd", 32'(b.dma_rd), 32'hC3);
    tick();
    // one-cycle access build
    c.dma_req = 2'b01; c.dma_rnw = 2'b01; c.dma_addr[20:0] = 21'h0ABCDE; c.mem_rd = 8'h3E; c.mem_slot = 1;
    #1 chk("a1_ack", 32'(c.dma_ack), 32'h1);
    tick();
    c.dma_req = '0; c.mem_slot = 0;
    chk("a1_sel", 32'(c.mem_sel), 1);
    chk("a1_addr", 32'(c.mem_addr), 32'h0ABCDE);
    chk("a1_end_early", 32'(c.dma_end), 0);
    tick();
    chk("a1_end", 32'(c.dma_end), 32'h1);
    chk("a1_rd", 32'(c.dma_rd), 32'h3E);
    chk("a1_sel_done", 32'(c.mem_sel), 0);
    tick();
    chk("a1_end_off", 32'(c.dma_end), 0);
    chk("a1_busy", 32'(busy1), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
